// File: rtl/irq_request_latch.sv
// Edge-triggered interrupt request latch: 8 sources, mask, per-source ack and sticky overflow.
// Optional feature: define IRQ_SYNC_EN to insert a two-flop synchroniser on req ahead of edge detection.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    input  logic       ack,
    input  logic [2:0] ack_id,
    input  logic       ovf_clr,
    output logic [7:0] pend,
    output logic       irq,
    output logic [7:0] mask,
    output logic [7:0] ovf
);

    logic [7:0] req_s;
    logic [7:0] edge_s;
    logic [7:0] ack_vec_s;
    logic [7:0] pend_s;
    logic [7:0] hist_q, hist_d;
    logic [7:0] raw_q, raw_d;
    logic [7:0] ovf_q, ovf_d;
    logic [7:0] mask_q, mask_d;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    // Two-flop synchroniser; reset high so a line held high across reset shows no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    // Next-state logic: an edge beats a same-cycle ack, and overflow only counts un-acked repeats.
    always_comb begin
        ack_vec_s = 8'h00;
        if (ack) begin
            ack_vec_s = 8'h01 << ack_id;
        end else begin
            ack_vec_s = 8'h00;
        end
        edge_s = req_s & ~hist_q;
        hist_d = req_s;
        raw_d  = (raw_q & ~ack_vec_s) | edge_s;
        if (ovf_clr) begin
            ovf_d = 8'h00;
        end else begin
            ovf_d = ovf_q;
        end
        ovf_d = ovf_d | (edge_s & raw_q & ~ack_vec_s);
        if (mask_wr) begin
            mask_d = mask_data;
        end else begin
            mask_d = mask_q;
        end
    end

    // State registers; reset overrides every strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 8'hFF;
            raw_q  <= 8'h00;
            ovf_q  <= 8'h00;
            mask_q <= 8'hFF;
        end else begin
            hist_q <= hist_d;
            raw_q  <= raw_d;
            ovf_q  <= ovf_d;
            mask_q <= mask_d;
        end
    end

    assign pend_s = raw_q & ~mask_q;
    assign pend   = pend_s;
    assign irq    = |pend_s;
    assign mask   = mask_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/irq_request_latch.md
IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

Interface
REQ-001 The block SHALL expose the following ports.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  8  raw request lines; bit n = source n
- mask_wr  in  1  strobe: load mask_data into mask
- mask_data  in  8  new mask value; 1 = source masked
- ack  in  1  strobe: clear pending bit selected by ack_id
- ack_id  in  3  index of source being acknowledged; fed back from the downstream priority encoder output
- ovf_clr  in  1  strobe: clear all overflow flags
- pend  out  8  masked pending vector; drives the downstream priority encoder input
- irq  out  1  any masked pending bit set
- mask  out  8  current mask register
- ovf  out  8  sticky per-source overflow flags
REQ-002 The block SHALL use one clock, clk, with a synchronous, active-high reset, rst.

Function
REQ-003 The block SHALL detect a rising edge on source n when the sampled req[n] = 1 and the previously sampled value = 0; level-high without an edge SHALL NOT set pending.
REQ-004 On a detected edge, the raw pending bit n SHALL be set at that clock edge: 1-cycle latency from req sampled high to pend[n] (when unmasked).
REQ-005 Raw pending bits SHALL latch regardless of mask; masking gates only the outputs.
REQ-006 pend SHALL equal raw_pending & ~mask, combinationally from registers; irq SHALL equal the OR-reduction of pend.
REQ-007 ack = 1 SHALL clear raw pending bit ack_id at the clock edge, whether or not that bit is masked or set; ack on a clear bit is a no-op.
REQ-008 Simultaneous ack and new edge on the same bit: the edge SHALL win; the bit stays set and ovf is not set.
REQ-009 A new edge on a bit already pending and not being acked in that cycle SHALL set ovf[n]; pending stays 1 and no count is kept.
REQ-010 ovf_clr = 1 SHALL clear all ovf bits; an ovf set in the same cycle SHALL win for that bit.
REQ-011 mask_wr = 1 SHALL load mask_data at the clock edge; the new mask SHALL affect pend/irq from the following cycle.
REQ-012 Edges on different sources in the same cycle SHALL all latch; the block performs no prioritisation.
REQ-013 Combinational paths from any input to pend/irq SHALL NOT exist.

Reset
REQ-014 While rst = 1, at each clock edge: raw_pending = 8'h00, ovf = 8'h00, mask = 8'hFF (all masked), edge-history registers = 8'hFF.
REQ-015 Consequently pend = 8'h00 and irq = 0 during and after reset; a req line held high across reset release SHALL NOT produce an edge until it drops and rises again.
REQ-016 rst SHALL override ack, mask_wr, ovf_clr and edges in the same cycle; reset mid-operation discards all pending and overflow state.

Configuration
REQ-017 Macro IRQ_SYNC_EN: when defined, each req bit SHALL pass through a two-flop synchroniser (reset to 1) before edge detection, giving 3-cycle req-to-pend latency.
REQ-018 Without IRQ_SYNC_EN, req SHALL feed edge detection directly (1-cycle latency, REQ-004); all other behaviour is identical.

Verification
REQ-019 Reset, mask 8'h00, req 8'h00 -> 8'h24 -> pend = 8'h24 and irq = 1 one cycle later (three cycles with IRQ_SYNC_EN).
REQ-020 pend = 8'h04, ack = 1, ack_id = 3'd2 -> pend = 8'h00 and irq = 0 next cycle; ovf = 8'h00.
REQ-021 Mask 8'hFF, edge on req[7] -> pend = 8'h00 and irq = 0; write mask 8'h7F -> pend = 8'h80 the cycle after mask_wr.
REQ-022 Bit 1 pending, second edge on req[1] with no ack -> ovf = 8'h02 and pend[1] = 1; same edge in a cycle with ack on id 1 -> pend[1] = 1 and ovf unchanged.
REQ-023 req = 8'hFF held through reset, then mask 8'h00 -> pend = 8'h00 until req[0] goes 0 then 1 -> pend = 8'h01.
REQ-024 rst asserted while pend = 8'h81 and ovf = 8'h01 -> next cycle pend = 8'h00, ovf = 8'h00, mask = 8'hFF, irq = 0.
